// File: rtl/alu_mdu.sv
// alu_mdu: WIDTH-bit combinational ALU plus a multi-cycle multiply/divide unit.
// The ALU (r/z) is purely combinational. The MDU runs one bit per cycle through
// the states IDLE -> RUN -> FIX and writes HI/LO with a one-cycle done pulse.
// Optional feature: define ALU_MDU_SIGNED_EN to make MULT/DIV (mdop[0]=1) signed.
// Without it, mdop[0] is ignored and every operation is unsigned.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] r,
  output logic             z,
  input  logic             start,
  input  logic [1:0]       mdop,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SHW:0]           cnt;
  logic [2*WIDTH-1:0]     acc;
  logic [WIDTH-1:0]       opnd;
  logic [WIDTH-1:0]       a_cap;
  logic                   is_div;
  logic                   sign_a;
  logic                   sign_b;

  logic [SHW-1:0]         shamt;
  logic [WIDTH-1:0]       sra_res;
  logic                   signed_op;
  logic                   sign_a_in;
  logic                   sign_b_in;
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic [WIDTH:0]         mul_sum;
  logic [WIDTH:0]         div_shift;
  logic [WIDTH:0]         div_diff;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       quot;
  logic [WIDTH-1:0]       rem;

  assign shamt   = a[SHW-1:0];
  assign sra_res = $signed(b) >>> shamt;

  // Single-cycle ALU result selected by aluc; low three bits pick the op class
  always_comb begin
    r = '0;
    case (aluc[2:0])
      3'b000:  r = a + b;
      3'b100:  r = a - b;
      3'b001:  r = a & b;
      3'b101:  r = a | b;
      3'b010:  r = a ^ b;
      3'b110:  r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      3'b011:  r = b << shamt;
      3'b111:  r = aluc[3] ? sra_res : (b >> shamt);
      default: r = '0;
    endcase
  end

  assign z = ~|r;

`ifdef ALU_MDU_SIGNED_EN
  assign signed_op = mdop[0];
`else
  logic unused_mdop0;
  assign unused_mdop0 = mdop[0];
  assign signed_op    = 1'b0;
`endif

  // Operands are reduced to magnitudes at capture; the signs are kept for FIX
  always_comb begin
    sign_a_in = signed_op & a[WIDTH-1];
    sign_b_in = signed_op & b[WIDTH-1];
    mag_a     = sign_a_in ? -a : a;
    mag_b     = sign_b_in ? -b : b;
  end

  // One iteration of shift-add multiply and of restoring division
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
  end

  // Sign correction applied to the finished magnitudes
  always_comb begin
    quot = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    prod = acc;
    if (sign_a ^ sign_b) prod = -acc;
    if (sign_a ^ sign_b) quot = -acc[WIDTH-1:0];
    if (sign_a)          rem  = -acc[2*WIDTH-1:WIDTH];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: RUN lasts WIDTH cycles, FIX exactly one
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == (SHW+1)'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // MDU datapath: capture, iterate, then publish HI/LO with a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_cap  <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= (SHW+1)'(WIDTH);
            is_div <= mdop[1];
            sign_a <= sign_a_in;
            sign_b <= sign_b_in;
            a_cap  <= a;
            if (mdop[1]) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end
        end
        RUN: begin
          cnt <= cnt - (SHW+1)'(1);
          if (is_div) begin
            if (!div_diff[WIDTH])
              acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
              acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            if (opnd == '0) begin
              lo <= '1;
              hi <= a_cap;
            end else begin
              lo <= quot;
              hi <= rem;
            end
          end else begin
            lo <= prod[WIDTH-1:0];
            hi <= prod[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: self-checking bench for alu_mdu at WIDTH = 32.
// Expected values come from a plain-arithmetic reference model of the ALU and
// of MULT/DIV semantics; the signed model follows ALU_MDU_SIGNED_EN.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic [31:0] r;
  logic        z;
  logic        start;
  logic [1:0]  mdop;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .aluc  (aluc),
    .r     (r),
    .z     (z),
    .start (start),
    .mdop  (mdop),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Reference ALU written from the operation table
  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    logic [31:0] fill;
    sh = x[4:0];
    fill = 32'hFFFF_FFFF;
    casez (op)
      4'b?000: return x + y;
      4'b?100: return x - y;
      4'b?001: return x & y;
      4'b?101: return x | y;
      4'b?010: return x ^ y;
      4'b?110: return {y[15:0], 16'h0000};
      4'b?011: return y << sh;
      4'b0111: return y >> sh;
      default: return (y >> sh) | (y[31] ? ~(fill >> sh) : 32'h0);
    endcase
  endfunction

  // Reference MULT/DIV using native 64-bit and signed integer arithmetic
  function automatic void model_md(input logic [1:0] op, input logic [31:0] ma, input logic [31:0] mb,
                                   output logic [31:0] mhi, output logic [31:0] mlo);
    bit sgn;
    longint sp;
    logic [63:0] up;
`ifdef ALU_MDU_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    if (!op[1]) begin
      if (sgn) begin
        sp = longint'(int'(ma)) * longint'(int'(mb));
        up = sp;
      end else begin
        up = {32'h0, ma} * {32'h0, mb};
      end
      mhi = up[63:32];
      mlo = up[31:0];
    end else if (mb == 32'h0) begin
      mhi = ma;
      mlo = 32'hFFFF_FFFF;
    end else if (sgn) begin
      if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
        mlo = 32'h8000_0000;
        mhi = 32'h0;
      end else begin
        mlo = int'(ma) / int'(mb);
        mhi = int'(ma) % int'(mb);
      end
    end else begin
      mlo = ma / mb;
      mhi = ma % mb;
    end
  endfunction

  // One comparison: counts it, and on mismatch counts and reports the failure
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Drive ALU operands and compare r/z against the model after settling
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] exp_r;
    aluc = op;
    a = x;
    b = y;
    #1;
    exp_r = model_alu(op, x, y);
    checkOutput({tag, "_r"}, {32'h0, r}, {32'h0, exp_r});
    checkOutput({tag, "_z"}, {63'h0, z}, {63'h0, (exp_r == 32'h0)});
  endtask

  // Launch one MDU op; scramble operands while busy, optionally pulse a stray start
  task automatic runMd(input string tag, input logic [1:0] op, input logic [31:0] oa, input logic [31:0] ob, input bit inject);
    logic [31:0] ehi;
    logic [31:0] elo;
    int edges;
    int busy_cnt;
    bit seen;
    model_md(op, oa, ob, ehi, elo);
    mdop = op;
    a = oa;
    b = ob;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput({tag, "_done_low_after_start"}, {63'h0, done}, 64'h0);
    edges = 0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      a = $urandom;
      b = $urandom;
      mdop = 2'($urandom);
      start = (inject && i == 5);
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    checkOutput({tag, "_done_seen"}, {63'h0, seen}, 64'h1);
    checkOutput({tag, "_latency"}, 64'(edges), 64'd33);
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    checkOutput({tag, "_hi"}, {32'h0, hi}, {32'h0, ehi});
    checkOutput({tag, "_lo"}, {32'h0, lo}, {32'h0, elo});
  endtask

  initial begin
    int late_done;
    rst = 1'b1;
    start = 1'b0;
    mdop = 2'b00;
    a = '0;
    b = '0;
    aluc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_hi", {32'h0, hi}, 64'h0);
    checkOutput("reset_lo", {32'h0, lo}, 64'h0);
    checkOutput("reset_busy", {63'h0, busy}, 64'h0);
    checkOutput("reset_done", {63'h0, done}, 64'h0);

    applyStimulus("add_wrap", 4'b0000, 32'h7FFF_FFFF, 32'h1);
    checkOutput("add_wrap_const", {32'h0, r}, 64'h8000_0000);
    applyStimulus("sub_zero", 4'b0100, 32'd5, 32'd5);
    checkOutput("sub_zero_z_const", {63'h0, z}, 64'h1);
    applyStimulus("sra", 4'b1111, 32'd4, 32'h8000_0000);
    checkOutput("sra_const", {32'h0, r}, 64'hF800_0000);
    applyStimulus("srl", 4'b0111, 32'd4, 32'h8000_0000);
    checkOutput("srl_const", {32'h0, r}, 64'h0800_0000);
    applyStimulus("lui", 4'b0110, 32'h0, 32'h0000_1234);
    checkOutput("lui_const", {32'h0, r}, 64'h1234_0000);
    applyStimulus("sll_hi", 4'b1011, 32'hFFFF_FFE3, 32'h0000_00F1);
    for (int i = 0; i < 24; i++)
      applyStimulus("alu_rand", 4'($urandom), $urandom, $urandom);

    runMd("multu_max", 2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0);
    checkOutput("multu_max_hi_const", {32'h0, hi}, 64'h1);
    checkOutput("multu_max_lo_const", {32'h0, lo}, 64'hFFFF_FFFE);

    runMd("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
`ifdef ALU_MDU_SIGNED_EN
    checkOutput("mult_neg_hi_const", {32'h0, hi}, 64'hFFFF_FFFF);
    checkOutput("mult_neg_lo_const", {32'h0, lo}, 64'hFFFF_FFEB);
`endif
    runMd("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef ALU_MDU_SIGNED_EN
    checkOutput("div_neg_lo_const", {32'h0, lo}, 64'hFFFF_FFFD);
    checkOutput("div_neg_hi_const", {32'h0, hi}, 64'hFFFF_FFFF);
`else
    checkOutput("div_uns_lo_const", {32'h0, lo}, 64'h7FFF_FFFC);
    checkOutput("div_uns_hi_const", {32'h0, hi}, 64'h1);
`endif

    runMd("divu_zero", 2'b10, 32'd100, 32'd0, 1'b1);
    checkOutput("divu_zero_lo_const", {32'h0, lo}, 64'hFFFF_FFFF);
    checkOutput("divu_zero_hi_const", {32'h0, hi}, 64'd100);
    runMd("div_zero_s", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0);
    runMd("min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
    runMd("min_neg1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 6; i++)
      runMd("md_rand", 2'($urandom), $urandom, $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 15)) : $urandom, i == 2);

    mdop = 2'b00;
    a = 32'h1234_5677;
    b = 32'h0BAD_F00D;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_mid_busy", {63'h0, busy}, 64'h0);
    checkOutput("rst_mid_done", {63'h0, done}, 64'h0);
    checkOutput("rst_mid_hi", {32'h0, hi}, 64'h0);
    checkOutput("rst_mid_lo", {32'h0, lo}, 64'h0);
    late_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) late_done++;
    end
    checkOutput("rst_mid_no_late_done", 64'(late_done), 64'h0);

    start = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    checkOutput("rst_over_start_busy", {63'h0, busy}, 64'h0);

    runMd("multu_6x7", 2'b00, 32'd6, 32'd7, 1'b0);
    checkOutput("multu_6x7_lo_const", {32'h0, lo}, 64'd42);
    checkOutput("multu_6x7_hi_const", {32'h0, hi}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
